// File: rtl/uart_status_link_pkg.sv
// Shared types and frame constants for the UART status link.
// Holds the FSM state enums and the per-index frame byte builder.
package uart_status_link_pkg;

    localparam int         FRAME_LEN = 12;
    localparam logic [7:0] HDR0      = 8'h55;
    localparam logic [7:0] HDR1      = 8'hAA;
    // XOR of the fixed filler bytes 0x04..0x0A
    localparam logic [7:0] FILL_XOR  = 8'h04 ^ 8'h05 ^ 8'h06 ^ 8'h07 ^ 8'h08 ^ 8'h09 ^ 8'h0A;

    typedef enum logic [1:0] {
        GEN_IDLE,
        GEN_SEND,
        GEN_WAIT_BUSY,
        GEN_WAIT_DONE
    } gen_state_e;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;

    function automatic logic [7:0] frame_byte(input logic [3:0] idx,
                                              input logic [7:0] led_s,
                                              input logic [7:0] cnt_s);
        logic [7:0] b;
        case (idx)
            4'd0:    b = HDR0;
            4'd1:    b = HDR1;
            4'd2:    b = led_s;
            4'd3:    b = cnt_s;
            4'd11:   b = HDR0 ^ HDR1 ^ FILL_XOR ^ led_s ^ cnt_s;
            default: b = {4'h0, idx};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_status_link_rx.sv
// 8N1 deserializer: 2-flop sync, falling-edge start, mid-bit sampling into led.
// Latency: led updates one cycle after the stop-bit midpoint sample; no backpressure.
module uart_status_link_rx #(
    parameter int BPS_NUM = 645
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] led
);
    import uart_status_link_pkg::*;

    localparam int             CW   = $clog2(BPS_NUM);
    localparam logic [CW-1:0]  LAST = CW'(BPS_NUM - 1);
    localparam logic [CW-1:0]  HALF = CW'(BPS_NUM / 2 - 1);

    uart_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    led_q, led_d;
    logic          rx_meta_q, rx_sync_q, rx_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= UART_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            led_q     <= '0;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            led_q     <= led_d;
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        led_d   = led_q;
        case (state_q)
            UART_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = UART_START;
                    cnt_d   = '0;
                end
            end
            UART_START: begin
                // A start bit that is high again at its midpoint was a glitch
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? UART_IDLE : UART_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            UART_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = UART_STOP;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            UART_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = UART_IDLE;
                    if (rx_sync_q) led_d = shift_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    assign led = led_q;

endmodule

// File: rtl/uart_status_link_tx.sv
// 8N1 serializer: start, 8 data bits LSB first, stop, each BPS_NUM cycles.
// Latency: start bit one cycle after tx_pulse; pulses while tx_busy are dropped.
module uart_status_link_tx #(
    parameter int BPS_NUM = 645
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_pulse,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       uart_tx
);
    import uart_status_link_pkg::*;

    localparam int            CW   = $clog2(BPS_NUM);
    localparam logic [CW-1:0] LAST = CW'(BPS_NUM - 1);

    uart_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= UART_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            UART_IDLE: begin
                if (tx_pulse) begin
                    state_d = UART_START;
                    cnt_d   = '0;
                    shift_d = tx_data;
                    tx_d    = 1'b0;
                end
            end
            UART_START: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = UART_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            UART_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = UART_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            UART_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = UART_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    assign tx_busy = (state_q != UART_IDLE);
    assign uart_tx = tx_q;

endmodule

// File: rtl/uart_status_link.sv
// Status UART: rx byte drives led; each enabled vsync rise sends a 12-byte status frame.
// Latency: first start bit 2 cycles after trigger; triggers during a frame are dropped.
module uart_status_link #(
    parameter int BPS_NUM = 645
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    input  logic [1:0] r_vsync_i,
    output logic [7:0] led,
    output logic       uart_tx
);
    import uart_status_link_pkg::*;

    gen_state_e gen_q, gen_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] fcnt_q, fcnt_d;
    logic [7:0] snap_led_q, snap_led_d;
    logic [7:0] snap_cnt_q, snap_cnt_d;
    logic       vs_prev_q;
    logic       trig, tx_pulse, tx_busy;
    logic [7:0] tx_data;

    uart_status_link_rx #(.BPS_NUM(BPS_NUM)) u_rx (
        .clk     (clk),
        .reset   (reset),
        .uart_rx (uart_rx),
        .led     (led)
    );

    uart_status_link_tx #(.BPS_NUM(BPS_NUM)) u_tx (
        .clk      (clk),
        .reset    (reset),
        .tx_pulse (tx_pulse),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .uart_tx  (uart_tx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gen_q      <= GEN_IDLE;
            idx_q      <= '0;
            fcnt_q     <= '0;
            snap_led_q <= '0;
            snap_cnt_q <= '0;
            vs_prev_q  <= 1'b0;
        end else begin
            gen_q      <= gen_d;
            idx_q      <= idx_d;
            fcnt_q     <= fcnt_d;
            snap_led_q <= snap_led_d;
            snap_cnt_q <= snap_cnt_d;
            vs_prev_q  <= r_vsync_i[0];
        end
    end

    assign trig    = r_vsync_i[0] && !vs_prev_q && r_vsync_i[1];
    assign tx_data = frame_byte(idx_q, snap_led_q, snap_cnt_q);

    always_comb begin
        gen_d      = gen_q;
        idx_d      = idx_q;
        fcnt_d     = fcnt_q;
        snap_led_d = snap_led_q;
        snap_cnt_d = snap_cnt_q;
        tx_pulse   = 1'b0;
        case (gen_q)
            GEN_IDLE: begin
                if (trig) begin
                    gen_d      = GEN_SEND;
                    idx_d      = '0;
                    snap_led_d = led;
                    snap_cnt_d = fcnt_q;
                end
            end
            GEN_SEND: begin
                tx_pulse = 1'b1;
                gen_d    = GEN_WAIT_BUSY;
            end
            GEN_WAIT_BUSY: begin
                if (tx_busy) gen_d = GEN_WAIT_DONE;
            end
            GEN_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (idx_q == 4'(FRAME_LEN - 1)) begin
                        gen_d  = GEN_IDLE;
                        fcnt_d = fcnt_q + 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        gen_d = GEN_SEND;
                    end
                end
            end
            default: gen_d = GEN_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_status_link.sv
// Scoreboarded bench: stimulus pushes expected frame bytes, a serial monitor decodes uart_tx and compares.
module tb_uart_status_link;

    localparam int BPS = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx = 1'b1;
    logic [1:0] r_vsync_i = 2'b00;
    logic [7:0] led;
    logic       uart_tx;

    int checks = 0;
    int failures = 0;
    int epoch = 0;
    int nrx = 0;
    bit mon_on = 0;

    logic [7:0] exp_q[$];
    logic [7:0] led_m = 8'h00;
    logic [7:0] fc_m = 8'h00;

    uart_status_link #(.BPS_NUM(BPS)) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .r_vsync_i (r_vsync_i),
        .led       (led),
        .uart_tx   (uart_tx)
    );

    always #5 clk = ~clk;

    task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference frame: header, led, counter, filler index bytes, running XOR checksum
    task automatic push_frame(input logic [7:0] l, input logic [7:0] c);
        logic [7:0] b[12];
        logic [7:0] x;
        b[0] = 8'h55;
        b[1] = 8'hAA;
        b[2] = l;
        b[3] = c;
        for (int i = 4; i <= 10; i++) b[i] = 8'(i);
        x = 8'h00;
        for (int i = 0; i <= 10; i++) x = x ^ b[i];
        b[11] = x;
        for (int i = 0; i < 12; i++) exp_q.push_back(b[i]);
    endtask

    task automatic vsync_pulse(input logic en);
        @(negedge clk) r_vsync_i = {en, 1'b0};
        @(negedge clk) r_vsync_i = {en, 1'b1};
        repeat (3) @(negedge clk);
        r_vsync_i = {en, 1'b0};
    endtask

    task automatic trigger_frame();
        push_frame(led_m, fc_m);
        fc_m = fc_m + 8'd1;
        vsync_pulse(1'b1);
    endtask

    task automatic wait_frame_done(input string nm);
        int k = 0;
        while (exp_q.size() != 0 && k < 120 * BPS + 600) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s frame_timeout remaining=%0d expected=0", nm, exp_q.size());
            exp_q.delete();
        end
        repeat (40) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (BPS) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    task automatic check_led(input string nm, input logic [7:0] exp, input bit wait_full);
        int k = 0;
        while ((wait_full || led !== exp) && k < BPS / 2 + 4) begin
            @(negedge clk);
            k++;
        end
        check8(nm, led, exp);
    endtask

    // Serial monitor: decodes uart_tx as 8N1 and scores each byte in order
    initial begin
        logic [7:0] d;
        logic       stp;
        int         ep;
        wait (mon_on);
        forever begin
            @(negedge uart_tx);
            ep = epoch;
            repeat (BPS / 2) @(posedge clk);
            #1;
            for (int i = 0; i < 8; i++) begin
                repeat (BPS) @(posedge clk);
                #1;
                d[i] = uart_tx;
            end
            repeat (BPS) @(posedge clk);
            #1;
            stp = uart_tx;
            if (ep == epoch) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_tx_byte actual=%h expected=none", d);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if ({stp, d} !== {1'b1, e}) begin
                        failures++;
                        $display("FAIL tx_byte actual=%h stop=%b expected=%h stop=1", d, stp, e);
                    end
                end
                nrx++;
            end
        end
    end

    initial begin
        logic [7:0] b;
        logic       stp;
        int         base;
        int         k;
        bit         tx_low;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check8("reset_uart_tx", {7'd0, uart_tx}, 8'h01);
        check8("reset_led", led, 8'h00);
        mon_on = 1;

        // vsync toggling with report disabled must not start a frame
        tx_low = 0;
        for (int i = 0; i < 6; i++) begin
            vsync_pulse(1'b0);
            for (int j = 0; j < 30; j++) begin
                @(negedge clk);
                if (uart_tx !== 1'b1) tx_low = 1;
            end
        end
        check8("disabled_tx_idle", {7'd0, tx_low}, 8'h00);

        send_rx(8'hA5, 1'b1);
        led_m = 8'hA5;
        check_led("rx_a5", led_m, 0);
        trigger_frame();
        repeat (600) @(negedge clk);
        vsync_pulse(1'b1);
        wait_frame_done("frame0");

        trigger_frame();
        wait_frame_done("frame1");

        send_rx(8'h3C, 1'b0);
        check_led("rx_bad_stop", led_m, 1);
        send_rx(8'h3C, 1'b1);
        led_m = 8'h3C;
        check_led("rx_3c", led_m, 0);

        @(negedge clk) uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * BPS) @(negedge clk);
        check8("rx_glitch", led, led_m);

        for (int r = 0; r < 3; r++) begin
            b   = 8'($urandom);
            stp = ($urandom_range(0, 3) != 0);
            send_rx(b, stp);
            if (stp) led_m = b;
            check_led("rx_random", led_m, !stp);
            trigger_frame();
            wait_frame_done("frame_random");
        end

        // Reset while byte 5's start bit is on the line
        base = nrx;
        trigger_frame();
        k = 0;
        while (nrx < base + 5 && k < 1500) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (uart_tx !== 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check8("byte5_start_seen", {7'd0, uart_tx}, 8'h00);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        epoch++;
        exp_q.delete();
        #1;
        check8("midframe_reset_tx", {7'd0, uart_tx}, 8'h01);
        check8("midframe_reset_led", led, 8'h00);
        led_m = 8'h00;
        fc_m  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        trigger_frame();
        wait_frame_done("frame_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
